// File: rtl/pipe_issue_sched_if.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched_if
//   Bundle between the instruction-slot FSMs and the issue/retire scheduler.
//
//   Handshake semantics (one place, applies to every signal below):
//     fetch_req[i] / ack[i]     slot i raises fetch_req while idle. The scheduler
//                               answers with a one-cycle ack pulse when the slot
//                               may start its next instruction.
//     complete[i] / wb_ack[i]   slot i holds complete high until it sees a
//                               one-cycle wb_ack pulse, which is its retire slot.
//     mem_req[i]  / mem_gnt[i]  mem_req is a level. mem_gnt stays high for as
//                               long as the owner keeps mem_req high.
//     flush / kill              flush is a one-cycle pulse. kill is a one-cycle
//                               pulse to each squashed slot.
//
//   Signals
//     en, stall, flush          global controls       (master -> slave)
//     fetch_req, complete,
//     mem_req  [NSLOT]          per-slot requests     (master -> slave)
//     flush_slot [PW]           surviving slot index  (master -> slave)
//     ack, wb_ack, mem_gnt,
//     kill     [NSLOT]          per-slot responses    (slave -> master)
//     issue_ptr, retire_ptr     pointers              (slave -> master)
//     inflight [CW], full       occupancy             (slave -> master)
//     dbg_state [2]             scheduler FSM state   (slave -> master)
// ---------------------------------------------------------------------------
interface pipe_issue_sched_if #(
    parameter int NSLOT = 3,
    parameter int PW    = $clog2(NSLOT),
    parameter int CW    = $clog2(NSLOT + 1)
);
    logic             en;
    logic             stall;
    logic [NSLOT-1:0] fetch_req;
    logic [NSLOT-1:0] complete;
    logic [NSLOT-1:0] mem_req;
    logic             flush;
    logic [PW-1:0]    flush_slot;

    logic [NSLOT-1:0] ack;
    logic [NSLOT-1:0] wb_ack;
    logic [NSLOT-1:0] mem_gnt;
    logic [NSLOT-1:0] kill;
    logic [PW-1:0]    issue_ptr;
    logic [PW-1:0]    retire_ptr;
    logic [CW-1:0]    inflight;
    logic             full;
    logic [1:0]       dbg_state;

    modport master (
        output en, stall, fetch_req, complete, mem_req, flush, flush_slot,
        input  ack, wb_ack, mem_gnt, kill, issue_ptr, retire_ptr, inflight,
               full, dbg_state
    );

    modport slave (
        input  en, stall, fetch_req, complete, mem_req, flush, flush_slot,
        output ack, wb_ack, mem_gnt, kill, issue_ptr, retire_ptr, inflight,
               full, dbg_state
    );
endinterface

// File: rtl/pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// pipe_issue_sched
//   Issue/retire scheduler for NSLOT instruction-slot FSMs that share one
//   fetch path, one memory port and one register-file write port.
//     - issue token (ack) handed out in round-robin program order
//     - write-back (wb_ack) granted oldest-first, so retire is in order
//     - memory port arbitrated oldest-first with a hold lock
//     - flush squashes every in-flight slot younger than flush_slot
//   All outputs are registered. Every decision uses the current inputs and
//   becomes visible on the next rising edge.
//
//   Ports
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     bus     slave modport of pipe_issue_sched_if (requests in, grants out)
// ---------------------------------------------------------------------------
module pipe_issue_sched #(
    parameter int NSLOT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_issue_sched_if.slave   bus
);
    localparam int PW = $clog2(NSLOT);
    localparam int CW = $clog2(NSLOT + 1);

    localparam logic [CW:0]   NSLOT_X  = (CW + 1)'(NSLOT);
    localparam logic [CW-1:0] FULL_CNT = CW'(NSLOT);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2,
        ST_FLUSH = 2'd3
    } state_e;

    // Distance of a slot from the oldest in-flight slot; 0 is the oldest.
    function automatic logic [CW-1:0] age_of(input logic [PW-1:0] slot,
                                             input logic [PW-1:0] base);
        logic [CW:0] s;
        logic [CW:0] b;
        logic [CW:0] d;
        s = (CW + 1)'(slot);
        b = (CW + 1)'(base);
        if (s >= b) d = s - b;
        else        d = s + NSLOT_X - b;
        return d[CW-1:0];
    endfunction

    // Slot that sits offs positions after base, wrapping modulo NSLOT
    // (handles non-power-of-two NSLOT).
    function automatic logic [PW-1:0] slot_at(input logic [PW-1:0] base,
                                              input logic [CW-1:0] offs);
        logic [CW:0] t;
        t = (CW + 1)'(base) + (CW + 1)'(offs);
        if (t >= NSLOT_X) t = t - NSLOT_X;
        return t[PW-1:0];
    endfunction

    state_e           state_q,      state_d;
    logic [PW-1:0]    issue_ptr_q,  issue_ptr_d;
    logic [PW-1:0]    retire_ptr_q, retire_ptr_d;
    logic [CW-1:0]    inflight_q,   inflight_d;
    logic             full_q,       full_d;
    logic [NSLOT-1:0] ack_q,        ack_d;
    logic [NSLOT-1:0] wb_ack_q,     wb_ack_d;
    logic [NSLOT-1:0] mem_gnt_q,    mem_gnt_d;
    logic [NSLOT-1:0] kill_q,       kill_d;

    logic [CW-1:0]    age [NSLOT];
    logic [NSLOT-1:0] in_flight;
    logic             flush_in;
    logic [CW-1:0]    flush_age;
    logic             flush_hit;
    logic             issue_go;
    logic             retire_go;

    // Age and in-flight status of each slot, and validity of the flush target.
    always_comb begin
        flush_in  = 1'b0;
        flush_age = age_of(bus.flush_slot, retire_ptr_q);
        for (int i = 0; i < NSLOT; i++) begin
            age[i]       = age_of(PW'(i), retire_ptr_q);
            in_flight[i] = (age[i] < inflight_q);
            if (PW'(i) == bus.flush_slot) flush_in = in_flight[i];
        end
        // A flush naming a slot that is not in flight is ignored entirely.
        flush_hit = bus.flush && flush_in;
    end

    // Next-state and registered-output logic.
    always_comb begin
        logic             keep;
        logic             found;
        logic [PW-1:0]    cand;

        state_d      = state_q;
        issue_ptr_d  = issue_ptr_q;
        retire_ptr_d = retire_ptr_q;
        inflight_d   = inflight_q;
        full_d       = full_q;
        ack_d        = '0;
        wb_ack_d     = '0;
        mem_gnt_d    = '0;
        kill_d       = '0;
        keep         = 1'b0;
        found        = 1'b0;
        cand         = '0;

        retire_go = (inflight_q != '0) && bus.complete[retire_ptr_q]
                    && !wb_ack_q[retire_ptr_q];
        // When FULL, a slot frees up in the same cycle it retires, so an issue
        // may pair with a retire; inflight then stays at NSLOT.
        // The ack_q term prevents re-granting a slot still seeing its ack.
        issue_go  = bus.fetch_req[issue_ptr_q] && !bus.stall
                    && (!full_q || retire_go) && !flush_hit
                    && !ack_q[issue_ptr_q];

        if (retire_go) begin
            wb_ack_d[retire_ptr_q] = 1'b1;
            retire_ptr_d           = slot_at(retire_ptr_q, ONE_C);
        end

        if (flush_hit) begin
            for (int i = 0; i < NSLOT; i++) begin
                kill_d[i] = in_flight[i] && (age[i] > flush_age);
            end
            issue_ptr_d = slot_at(bus.flush_slot, ONE_C);
            inflight_d  = retire_go ? flush_age : flush_age + ONE_C;
        end else begin
            if (issue_go) begin
                ack_d[issue_ptr_q] = 1'b1;
                issue_ptr_d        = slot_at(issue_ptr_q, ONE_C);
            end
            case ({issue_go, retire_go})
                2'b10:   inflight_d = inflight_q + ONE_C;
                2'b01:   inflight_d = inflight_q - ONE_C;
                default: inflight_d = inflight_q;
            endcase
        end

        // Memory port: the owner keeps it while it still requests and is still
        // in flight and not being killed; otherwise re-arbitrate oldest-first
        // in the same cycle.
        for (int i = 0; i < NSLOT; i++) begin
            if (mem_gnt_q[i] && bus.mem_req[i] && in_flight[i] && !kill_d[i]) begin
                mem_gnt_d[i] = 1'b1;
                keep         = 1'b1;
            end
        end
        if (!keep) begin
            for (int k = 0; k < NSLOT; k++) begin
                cand = slot_at(retire_ptr_q, CW'(k));
                if (!found && (CW'(k) < inflight_q) && bus.mem_req[cand]
                    && !kill_d[cand]) begin
                    mem_gnt_d[cand] = 1'b1;
                    found           = 1'b1;
                end
            end
        end

        full_d = (inflight_d == FULL_CNT);

        if (flush_hit)               state_d = ST_FLUSH;
        else if (inflight_d == '0)   state_d = ST_IDLE;
        else if (full_d)             state_d = ST_FULL;
        else                         state_d = ST_RUN;

        // en low is a synchronous return to the reset state.
        if (!bus.en) begin
            state_d      = ST_IDLE;
            issue_ptr_d  = '0;
            retire_ptr_d = '0;
            inflight_d   = '0;
            full_d       = 1'b0;
            ack_d        = '0;
            wb_ack_d     = '0;
            mem_gnt_d    = '0;
            kill_d       = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            issue_ptr_q  <= '0;
            retire_ptr_q <= '0;
            inflight_q   <= '0;
            full_q       <= 1'b0;
            ack_q        <= '0;
            wb_ack_q     <= '0;
            mem_gnt_q    <= '0;
            kill_q       <= '0;
        end else begin
            state_q      <= state_d;
            issue_ptr_q  <= issue_ptr_d;
            retire_ptr_q <= retire_ptr_d;
            inflight_q   <= inflight_d;
            full_q       <= full_d;
            ack_q        <= ack_d;
            wb_ack_q     <= wb_ack_d;
            mem_gnt_q    <= mem_gnt_d;
            kill_q       <= kill_d;
        end
    end

    assign bus.ack        = ack_q;
    assign bus.wb_ack     = wb_ack_q;
    assign bus.mem_gnt    = mem_gnt_q;
    assign bus.kill       = kill_q;
    assign bus.issue_ptr  = issue_ptr_q;
    assign bus.retire_ptr = retire_ptr_q;
    assign bus.inflight   = inflight_q;
    assign bus.full       = full_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_pipe_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_pipe_issue_sched
//   Directed bench for pipe_issue_sched with NSLOT=3. The stimulus thread pushes
//   each expected output event into exp_q before driving the inputs that cause
//   it. A monitor running on the falling edge pops and compares whenever the
//   DUT shows a pulse (ack/wb_ack/kill) or a change of mem_gnt. State that must
//   hold without producing an event is checked directly.
// ---------------------------------------------------------------------------
module tb_pipe_issue_sched;
    localparam int NSLOT = 3;
    localparam int PW    = 2;
    localparam int CW    = 2;
    localparam int W     = 4 * NSLOT + PW + PW + CW + 1;

    logic clk;
    logic rst_n;

    pipe_issue_sched_if #(.NSLOT(NSLOT)) bus ();

    pipe_issue_sched #(.NSLOT(NSLOT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    logic [NSLOT-1:0] prev_gnt;
    int               checks;
    int               errors;

    function automatic logic [W-1:0] mk(input logic [2:0] a, input logic [2:0] wb,
                                        input logic [2:0] g, input logic [2:0] k,
                                        input logic [1:0] ip, input logic [1:0] rp,
                                        input logic [1:0] inf, input logic fl);
        return {a, wb, g, k, ip, rp, inf, fl};
    endfunction

    function automatic logic [W-1:0] snap();
        return {bus.ack, bus.wb_ack, bus.mem_gnt, bus.kill,
                bus.issue_ptr, bus.retire_ptr, bus.inflight, bus.full};
    endfunction

    initial prev_gnt = '0;

    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        act = snap();
        if (rst_n && (((bus.ack | bus.wb_ack | bus.kill) != '0) || (bus.mem_gnt != prev_gnt))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event t=%0t: got %h, expected no event", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL event t=%0t: got %h (ack wb gnt kill ip rp inf full), expected %h",
                             $time, act, e);
                end
            end
        end
        prev_gnt = bus.mem_gnt;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, got, exp);
        end
    endtask

    task automatic push_fill();
        exp_q.push_back(mk(3'b001, 3'b000, 3'b000, 3'b000, 2'd1, 2'd0, 2'd1, 1'b0));
        exp_q.push_back(mk(3'b010, 3'b000, 3'b000, 3'b000, 2'd2, 2'd0, 2'd2, 1'b0));
        exp_q.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd3, 1'b1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.en         = 1'b1;
        bus.stall      = 1'b0;
        bus.fetch_req  = '0;
        bus.complete   = '0;
        bus.mem_req    = '0;
        bus.flush      = 1'b0;
        bus.flush_slot = '0;

        #3;
        check("reset_outputs", 32'(snap()), 32'd0);
        check("reset_state", 32'(bus.dbg_state), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Round-robin fill: three acks, then full and no further ack.
        push_fill();
        bus.fetch_req = 3'b111;
        repeat (5) step();
        bus.fetch_req = 3'b000;
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_inflight", 32'(bus.inflight), 32'd3);
        check("fill_state", 32'(bus.dbg_state), 32'd2);

        // A younger completion is ignored until the oldest completes.
        bus.complete = 3'b010;
        repeat (3) step();
        check("younger_ignored", 32'(bus.inflight), 32'd3);
        exp_q.push_back(mk(3'b000, 3'b001, 3'b000, 3'b000, 2'd0, 2'd1, 2'd2, 1'b0));
        exp_q.push_back(mk(3'b000, 3'b010, 3'b000, 3'b000, 2'd0, 2'd2, 2'd1, 1'b0));
        bus.complete = 3'b011;
        step();
        step();
        bus.complete = 3'b000;
        step();
        check("retire_inflight", 32'(bus.inflight), 32'd1);

        // en low returns to reset state; refill, then issue+retire together in FULL.
        bus.en = 1'b0;
        step();
        check("en_inflight", 32'(bus.inflight), 32'd0);
        check("en_state", 32'(bus.dbg_state), 32'd0);
        bus.en = 1'b1;
        push_fill();
        bus.fetch_req = 3'b111;
        repeat (3) step();
        exp_q.push_back(mk(3'b001, 3'b001, 3'b000, 3'b000, 2'd1, 2'd1, 2'd3, 1'b1));
        bus.fetch_req = 3'b001;
        bus.complete  = 3'b001;
        step();
        bus.fetch_req = 3'b000;
        bus.complete  = 3'b000;
        step();

        // Memory arbitration: oldest requester (slot1) wins and holds.
        exp_q.push_back(mk(3'b000, 3'b000, 3'b010, 3'b000, 2'd1, 2'd1, 2'd3, 1'b1));
        bus.mem_req = 3'b110;
        step();
        repeat (4) step();
        check("gnt_hold", 32'(bus.mem_gnt), 32'b010);
        exp_q.push_back(mk(3'b000, 3'b000, 3'b100, 3'b000, 2'd1, 2'd1, 2'd3, 1'b1));
        bus.mem_req = 3'b100;
        step();

        // en low drops the grant; refill and flush at slot0.
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd0, 1'b0));
        bus.mem_req = 3'b000;
        bus.en      = 1'b0;
        step();
        bus.en = 1'b1;
        push_fill();
        bus.fetch_req = 3'b111;
        repeat (3) step();
        bus.fetch_req = 3'b000;
        exp_q.push_back(mk(3'b000, 3'b000, 3'b100, 3'b000, 2'd0, 2'd0, 2'd3, 1'b1));
        bus.mem_req = 3'b100;
        step();
        exp_q.push_back(mk(3'b000, 3'b000, 3'b000, 3'b110, 2'd1, 2'd0, 2'd1, 1'b0));
        bus.flush      = 1'b1;
        bus.flush_slot = 2'd0;
        step();
        bus.flush = 1'b0;
        check("flush_state", 32'(bus.dbg_state), 32'd3);
        step();
        check("post_flush_state", 32'(bus.dbg_state), 32'd1);
        check("post_flush_gnt", 32'(bus.mem_gnt), 32'd0);

        // Flush naming a slot that is not in flight has no effect.
        bus.flush      = 1'b1;
        bus.flush_slot = 2'd2;
        step();
        bus.flush = 1'b0;
        step();
        check("ign_flush_inflight", 32'(bus.inflight), 32'd1);
        check("ign_flush_issue_ptr", 32'(bus.issue_ptr), 32'd1);
        check("ign_flush_retire_ptr", 32'(bus.retire_ptr), 32'd0);
        bus.mem_req = 3'b000;

        // Stall holds issue; release issues on the next edges; async reset mid-burst.
        bus.stall     = 1'b1;
        bus.fetch_req = 3'b110;
        repeat (5) step();
        check("stall_issue_ptr", 32'(bus.issue_ptr), 32'd1);
        check("stall_inflight", 32'(bus.inflight), 32'd1);
        exp_q.push_back(mk(3'b010, 3'b000, 3'b000, 3'b000, 2'd2, 2'd0, 2'd2, 1'b0));
        exp_q.push_back(mk(3'b100, 3'b000, 3'b000, 3'b000, 2'd0, 2'd0, 2'd3, 1'b1));
        bus.stall = 1'b0;
        step();
        step();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 32'(snap()), 32'd0);
        check("async_rst_state", 32'(bus.dbg_state), 32'd0);
        bus.fetch_req = 3'b000;
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();

        // ---------------- final report ----------------
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d left in queue, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
